// File: rtl/cva6_dfx_ctrl.sv
// ----------------------------------------------------------------------------
// cva6_dfx_ctrl : partial-reconfiguration sequencer for the CVA6 partition.
// Optional macro CVA6_DFX_CYCLE_CNT_EN adds the reconf_cycles_o counter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cva6_dfx_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned DRAIN_TIMEOUT   = 1024,
  parameter int unsigned RST_HOLD_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        reconf_start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  input  logic        aw_hs_i,
  input  logic        b_hs_i,
  input  logic        ar_hs_i,
  input  logic        r_last_hs_i,
  output logic        block_o,
  output logic        decouple_o,
  output logic        core_rst_no,
  output logic        load_start_o,
  input  logic        load_done_i,
`ifdef CVA6_DFX_CYCLE_CNT_EN
  output logic [31:0] reconf_cycles_o,
`endif
  input  logic        load_err_i
);

  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TMR_MAX = (DRAIN_TIMEOUT > RST_HOLD_CYCLES) ? DRAIN_TIMEOUT
                                                                      : RST_HOLD_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    DECOUPLE = 3'd2,
    LOAD     = 3'd3,
    RST_HOLD = 3'd4,
    RECOUPLE = 3'd5,
    ABORT    = 3'd6,
    FAIL     = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              decouple_q, decouple_d;
  logic              core_rst_q, core_rst_d;
  logic              load_start_q, load_start_d;
  logic              clr_cnt;

  // Increment saturates at the limit; decrement at zero is a no-op.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec && (cnt != CNT_MAX)) begin
      res = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - CNT_W'(1);
    end
    return res;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (clr_cnt) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      wr_cnt <= cnt_next(wr_cnt, aw_hs_i, b_hs_i);
      rd_cnt <= cnt_next(rd_cnt, ar_hs_i, r_last_hs_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      decouple_q   <= 1'b0;
      core_rst_q   <= 1'b1;
      load_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      decouple_q   <= decouple_d;
      core_rst_q   <= core_rst_d;
      load_start_q <= load_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    decouple_d   = decouple_q;
    core_rst_d   = core_rst_q;
    load_start_d = 1'b0;
    clr_cnt      = 1'b0;
    case (state_q)
      IDLE: begin
        if (reconf_start_i) begin
          state_d = DRAIN;
          busy_d  = 1'b1;
          error_d = 1'b0;
          timer_d = '0;
        end
      end
      DRAIN: begin
        if ((wr_cnt == '0) && (rd_cnt == '0)) begin
          state_d      = DECOUPLE;
          decouple_d   = 1'b1;
          core_rst_d   = 1'b0;
          load_start_d = 1'b1;
        end else if (timer_q == DRAIN_LAST) begin
          state_d = ABORT;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DECOUPLE: begin
        // Partition side is cut off from here on; nothing left to track.
        state_d = LOAD;
        clr_cnt = 1'b1;
      end
      LOAD: begin
        if (load_err_i) begin
          state_d = FAIL;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else if (load_done_i) begin
          state_d = RST_HOLD;
          timer_d = '0;
        end
      end
      RST_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          state_d    = RECOUPLE;
          decouple_d = 1'b0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RECOUPLE: begin
        state_d    = IDLE;
        core_rst_d = 1'b1;
        done_d     = 1'b1;
        busy_d     = 1'b0;
      end
      ABORT, FAIL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign decouple_o   = decouple_q;
  assign core_rst_no  = core_rst_q;
  assign load_start_o = load_start_q;
  assign block_o      = ((state_q != IDLE) && (state_q != ABORT)) ||
                        (wr_cnt == CNT_MAX) || (rd_cnt == CNT_MAX);

`ifdef CVA6_DFX_CYCLE_CNT_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= '0;
    end else if ((state_q == IDLE) && reconf_start_i) begin
      cycles_q <= '0;
    end else if (busy_q && (cycles_q != 32'hFFFF_FFFF)) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign reconf_cycles_o = cycles_q;
`endif

  wr_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(b_hs_i && !aw_hs_i && !clr_cnt && (wr_cnt == '0)));
  rd_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_last_hs_i && !ar_hs_i && !clr_cnt && (rd_cnt == '0)));

endmodule

`default_nettype wire

// File: tb/tb_cva6_dfx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cva6_dfx_ctrl : scoreboard bench for cva6_dfx_ctrl.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cva6_dfx_ctrl;

  localparam logic [6:0] M_START = 7'b0000001;
  localparam logic [6:0] M_AW    = 7'b0000010;
  localparam logic [6:0] M_B     = 7'b0000100;
  localparam logic [6:0] M_AR    = 7'b0001000;
  localparam logic [6:0] M_RL    = 7'b0010000;
  localparam logic [6:0] M_LD    = 7'b0100000;
  localparam logic [6:0] M_LE    = 7'b1000000;

  localparam int EV_LS   = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic reconf_start_i, aw_hs_i, b_hs_i, ar_hs_i, r_last_hs_i, load_done_i, load_err_i;
  logic busy_o, done_o, error_o, block_o, decouple_o, core_rst_no, load_start_o;
`ifdef CVA6_DFX_CYCLE_CNT_EN
  logic [31:0] reconf_cycles_o;
`endif

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t sb_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  logic err_prev = 1'b0;

  cva6_dfx_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .reconf_start_i (reconf_start_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .aw_hs_i        (aw_hs_i),
    .b_hs_i         (b_hs_i),
    .ar_hs_i        (ar_hs_i),
    .r_last_hs_i    (r_last_hs_i),
    .block_o        (block_o),
    .decouple_o     (decouple_o),
    .core_rst_no    (core_rst_no),
    .load_start_o   (load_start_o),
    .load_done_i    (load_done_i),
`ifdef CVA6_DFX_CYCLE_CNT_EN
    .reconf_cycles_o(reconf_cycles_o),
`endif
    .load_err_i     (load_err_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  task automatic sb_event(input int kind);
    ev_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_unexpected_event", kind, 0);
    end else begin
      e = sb_q.pop_front();
      check_val("sb_kind", kind, e.kind);
      check_val("sb_cycle", cyc, e.cyc);
    end
  endtask

  // Output monitor: every observed event must match the next expected one.
  always @(negedge clk_i) begin
    if (load_start_o) sb_event(EV_LS);
    if (done_o) sb_event(EV_DONE);
    if (error_o && !err_prev) sb_event(EV_ERR);
    err_prev = error_o;
  end

  task automatic drive(input logic [6:0] m, output int at);
    @(posedge clk_i);
    #1;
    {load_err_i, load_done_i, r_last_hs_i, ar_hs_i, b_hs_i, aw_hs_i, reconf_start_i} = m;
    at = cyc;
    @(posedge clk_i);
    #1;
    {load_err_i, load_done_i, r_last_hs_i, ar_hs_i, b_hs_i, aw_hs_i, reconf_start_i} = '0;
  endtask

  task automatic goto_cycle(input int t);
    do @(negedge clk_i); while (cyc < t);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_busy"}, busy_o, 0);
    check_val({tag, "_done"}, done_o, 0);
    check_val({tag, "_error"}, error_o, 0);
    check_val({tag, "_block"}, block_o, 0);
    check_val({tag, "_decouple"}, decouple_o, 0);
    check_val({tag, "_core_rst_n"}, core_rst_no, 1);
    check_val({tag, "_load_start"}, load_start_o, 0);
`ifdef CVA6_DFX_CYCLE_CNT_EN
    check_val({tag, "_cycles"}, reconf_cycles_o, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int d;
    int e;
    int x;
    rst_ni = 1'b0;
    {load_err_i, load_done_i, r_last_hs_i, ar_hs_i, b_hs_i, aw_hs_i, reconf_start_i} = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_vals("reset");
    rst_ni = 1'b1;

    // Clean reconfiguration, load_done 5 cycles after load_start.
    drive(M_START, t);
    push_ev(EV_LS, t + 2);
    goto_cycle(t + 2);
    check_val("t1_decouple", decouple_o, 1);
    check_val("t1_core_rst_n", core_rst_no, 0);
    check_val("t1_block", block_o, 1);
    check_val("t1_busy", busy_o, 1);
    goto_cycle(t + 6);
    drive(M_LD, d);
    push_ev(EV_DONE, d + 18);
    goto_cycle(d + 17);
    check_val("t1_recouple_decouple", decouple_o, 0);
    check_val("t1_recouple_core_rst_n", core_rst_no, 0);
    goto_cycle(d + 18);
    check_val("t1_end_core_rst_n", core_rst_no, 1);
    check_val("t1_end_busy", busy_o, 0);
    check_val("t1_end_block", block_o, 0);

    // Drain of three outstanding writes.
    for (int i = 0; i < 3; i++) drive(M_AW, x);
    goto_cycle(x + 1);
    check_val("t2_idle_block", block_o, 0);
    drive(M_START, t);
    goto_cycle(t + 3);
    check_val("t2_drain_block", block_o, 1);
    check_val("t2_drain_decouple", decouple_o, 0);
    for (int i = 0; i < 3; i++) begin
      drive(M_B, x);
      if (i < 2) begin
        goto_cycle(x + 5);
        check_val("t2_wait_block", block_o, 1);
        check_val("t2_wait_decouple", decouple_o, 0);
        goto_cycle(x + 9);
      end
    end
    push_ev(EV_LS, x + 2);
    goto_cycle(x + 1);
    check_val("t2_pre_decouple", decouple_o, 0);
    goto_cycle(x + 2);
    check_val("t2_decouple", decouple_o, 1);
    drive(M_LD, d);
    push_ev(EV_DONE, d + 18);
    goto_cycle(d + 18);
    check_val("t2_end_core_rst_n", core_rst_no, 1);

    // Drain timeout with one read never completing.
    drive(M_AR, x);
    drive(M_START, t);
    push_ev(EV_ERR, t + 1025);
    goto_cycle(t + 1024);
    check_val("t3_pre_error", error_o, 0);
    check_val("t3_pre_block", block_o, 1);
    goto_cycle(t + 1025);
    check_val("t3_error", error_o, 1);
    check_val("t3_busy", busy_o, 0);
    check_val("t3_decouple", decouple_o, 0);
    check_val("t3_core_rst_n", core_rst_no, 1);
    goto_cycle(t + 1026);
    check_val("t3_block_released", block_o, 0);
    drive(M_RL, x);

    // Loader failure, then a fresh start recovers.
    drive(M_START, t);
    push_ev(EV_LS, t + 2);
    goto_cycle(t + 4);
    drive(M_LE, e);
    push_ev(EV_ERR, e + 1);
    goto_cycle(e + 1);
    check_val("t4_error", error_o, 1);
    check_val("t4_busy", busy_o, 0);
    check_val("t4_decouple", decouple_o, 1);
    check_val("t4_core_rst_n", core_rst_no, 0);
    goto_cycle(e + 3);
    check_val("t4_idle_decouple", decouple_o, 1);
    check_val("t4_idle_core_rst_n", core_rst_no, 0);
    drive(M_START, t);
    push_ev(EV_LS, t + 2);
    goto_cycle(t + 1);
    check_val("t4_error_cleared", error_o, 0);
    check_val("t4_busy_again", busy_o, 1);
    goto_cycle(t + 4);
    drive(M_LD, d);
    push_ev(EV_DONE, d + 18);
    goto_cycle(d + 18);
    check_val("t4_end_error", error_o, 0);
    check_val("t4_end_decouple", decouple_o, 0);
    check_val("t4_end_core_rst_n", core_rst_no, 1);

    // Outstanding-limit blocking while idle.
    for (int i = 0; i < 7; i++) drive(M_AW, x);
    goto_cycle(x + 1);
    check_val("t5_block_at7", block_o, 0);
    drive(M_AW, x);
    goto_cycle(x + 1);
    check_val("t5_block_at8", block_o, 1);
    drive(M_AW | M_B, x);
    goto_cycle(x + 1);
    check_val("t5_block_simul", block_o, 1);
    drive(M_B, x);
    goto_cycle(x + 1);
    check_val("t5_block_at7_again", block_o, 0);
    for (int i = 0; i < 7; i++) drive(M_B, x);

    // Asynchronous reset in the middle of LOAD.
    drive(M_START, t);
    push_ev(EV_LS, t + 2);
    goto_cycle(t + 4);
    check_val("t6_in_load_decouple", decouple_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_vals("t6_async");
    @(negedge clk_i);
    rst_ni = 1'b1;
    goto_cycle(cyc + 2);
    check_reset_vals("t6_after");

    check_val("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
